// File: rtl/demux_1x2_32b_buf_pkg.sv
// Shared constants and buffer state encoding for the registered 1-to-2 demux.
// The optional per-output transfer counters are enabled by the DEMUX_CNT_EN macro.
package demux_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

   localparam logic SEL_Y0 = 1'b0;
   localparam logic SEL_Y1 = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/demux_1x2_32b_buf_hold_reg.sv
// One-entry valid/ready holding register (EMPTY <-> FULL) used once per demux output.
// With DEMUX_CNT_EN defined it also counts the words drained through it.
module hold_reg_32b
   import demux_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
`ifdef DEMUX_CNT_EN
   ,
   parameter int CNT_W  = DEF_CNT_W
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data,
   output logic              full,
   output logic              can_load
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt
`endif
);

   buf_state_t        state;
   buf_state_t        state_next;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_next;
   logic              drain;

   assign drain    = (state == FULL) && out_ready;
   assign can_load = (state == EMPTY) || out_ready;
   assign data     = data_q;
   assign full     = (state == FULL);

   // A load wins over a same-cycle drain so the buffer can stream one word per cycle.
   always_comb begin
      state_next = state;
      data_next  = data_q;
      if (load) begin
         state_next = FULL;
         data_next  = din;
      end else if (drain) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         data_q <= '0;
      end else begin
         state  <= state_next;
         data_q <= data_next;
      end
   end

`ifdef DEMUX_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (drain) begin
         cnt <= cnt + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/demux_1x2_32b_buf.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into one of two holding buffers.
// Define DEMUX_CNT_EN to add the Cnt0/Cnt1 delivered-word counters.
module demux_1x2_32b_buf
   import demux_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] X,
   input  logic              Sel,
   input  logic              In_Valid,
   output logic              In_Ready,
   output logic [DATA_W-1:0] Y0,
   output logic              Y0_Valid,
   input  logic              Y0_Ready,
   output logic [DATA_W-1:0] Y1,
   output logic              Y1_Valid,
   input  logic              Y1_Ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  Cnt0,
   output logic [CNT_W-1:0]  Cnt1
`endif
);

   logic can_load0;
   logic can_load1;
   logic accept;
   logic load0;
   logic load1;

   // Readiness looks only at the selected buffer, so a stalled channel never blocks the other.
   assign In_Ready = (Sel == SEL_Y1) ? can_load1 : can_load0;
   assign accept   = In_Valid && In_Ready;
   assign load0    = accept && (Sel == SEL_Y0);
   assign load1    = accept && (Sel == SEL_Y1);

   hold_reg_32b #(
      .DATA_W   (DATA_W)
`ifdef DEMUX_CNT_EN
      ,
      .CNT_W    (CNT_W)
`endif
   ) u_buf0 (
      .clk      (Clk),
      .reset    (Reset),
      .load     (load0),
      .din      (X),
      .out_ready(Y0_Ready),
      .data     (Y0),
      .full     (Y0_Valid),
      .can_load (can_load0)
`ifdef DEMUX_CNT_EN
      ,
      .cnt      (Cnt0)
`endif
   );

   hold_reg_32b #(
      .DATA_W   (DATA_W)
`ifdef DEMUX_CNT_EN
      ,
      .CNT_W    (CNT_W)
`endif
   ) u_buf1 (
      .clk      (Clk),
      .reset    (Reset),
      .load     (load1),
      .din      (X),
      .out_ready(Y1_Ready),
      .data     (Y1),
      .full     (Y1_Valid),
      .can_load (can_load1)
`ifdef DEMUX_CNT_EN
      ,
      .cnt      (Cnt1)
`endif
   );

endmodule

// File: tb/tb_demux_1x2_32b_buf.sv
// Directed table-driven bench for demux_1x2_32b_buf, plus reset-mid-operation and counter-wrap sequences.
// Counter checks are compiled in only when DEMUX_CNT_EN is defined.
module tb_demux_1x2_32b_buf;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [DW-1:0] x;
   logic          sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] y0;
   logic          y0_valid;
   logic          y0_ready;
   logic [DW-1:0] y1;
   logic          y1_valid;
   logic          y1_ready;
`ifdef DEMUX_CNT_EN
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
`endif

   int total_checks;
   int passed_checks;

   typedef struct {
      logic          in_valid;
      logic          sel;
      logic [DW-1:0] x;
      logic          y0_ready;
      logic          y1_ready;
      logic          exp_in_ready;
      logic [DW-1:0] exp_y0;
      logic          exp_y0_valid;
      logic [DW-1:0] exp_y1;
      logic          exp_y1_valid;
      int            exp_cnt0;
      int            exp_cnt1;
   } vec_t;

   vec_t vecs[$];

   demux_1x2_32b_buf #(
      .DATA_W  (DW),
      .CNT_W   (CW)
   ) dut (
      .Clk     (clk),
      .Reset   (reset),
      .X       (x),
      .Sel     (sel),
      .In_Valid(in_valid),
      .In_Ready(in_ready),
      .Y0      (y0),
      .Y0_Valid(y0_valid),
      .Y0_Ready(y0_ready),
      .Y1      (y1),
      .Y1_Valid(y1_valid),
      .Y1_Ready(y1_ready)
`ifdef DEMUX_CNT_EN
      ,
      .Cnt0    (cnt0),
      .Cnt1    (cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total_checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         passed_checks++;
      end
   endtask

   task automatic add_vec(input logic iv, input logic s, input logic [DW-1:0] xv,
                          input logic r0, input logic r1, input logic e_inr,
                          input logic [DW-1:0] e_y0, input logic e_v0,
                          input logic [DW-1:0] e_y1, input logic e_v1,
                          input int e_c0, input int e_c1);
      vec_t v;
      v.in_valid = iv;       v.sel = s;            v.x = xv;
      v.y0_ready = r0;       v.y1_ready = r1;      v.exp_in_ready = e_inr;
      v.exp_y0 = e_y0;       v.exp_y0_valid = e_v0;
      v.exp_y1 = e_y1;       v.exp_y1_valid = e_v1;
      v.exp_cnt0 = e_c0;     v.exp_cnt1 = e_c1;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic s, input logic [DW-1:0] xv,
                        input logic r0, input logic r1);
      in_valid = iv;
      sel      = s;
      x        = xv;
      y0_ready = r0;
      y1_ready = r1;
   endtask

   task automatic check_outputs(input string tag, input logic [DW-1:0] e_y0, input logic e_v0,
                                input logic [DW-1:0] e_y1, input logic e_v1,
                                input int e_c0, input int e_c1);
      check_val({tag, " Y0"}, y0, e_y0);
      check_val({tag, " Y0_Valid"}, {31'd0, y0_valid}, {31'd0, e_v0});
      check_val({tag, " Y1"}, y1, e_y1);
      check_val({tag, " Y1_Valid"}, {31'd0, y1_valid}, {31'd0, e_v1});
`ifdef DEMUX_CNT_EN
      check_val({tag, " Cnt0"}, {28'd0, cnt0}, DW'(e_c0 % 16));
      check_val({tag, " Cnt1"}, {28'd0, cnt1}, DW'(e_c1 % 16));
`else
      if (e_c0 < 0 || e_c1 < 0) begin
         $display("[TB] bad expected count in %s", tag);
      end
`endif
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;

      // in_valid, sel, x, r0, r1 | in_ready, Y0, V0, Y1, V1, Cnt0, Cnt1 (state after the edge)
      add_vec(1, 0, 32'h0000_0030, 1, 0, 1, 32'h0000_0030, 1, 32'h0, 0, 0, 0);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'h0000_0030, 0, 32'h0, 0, 1, 0);
      add_vec(1, 1, 32'h0010_0000, 0, 0, 1, 32'h0000_0030, 0, 32'h0010_0000, 1, 1, 0);
      add_vec(1, 1, 32'h0000_0001, 0, 0, 0, 32'h0000_0030, 0, 32'h0010_0000, 1, 1, 0);
      add_vec(1, 1, 32'h0000_0001, 0, 1, 1, 32'h0000_0030, 0, 32'h0000_0001, 1, 1, 1);
      add_vec(1, 0, 32'h0000_ABCD, 0, 0, 1, 32'h0000_ABCD, 1, 32'h0000_0001, 1, 1, 1);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h0000_ABCD, 0, 32'h0000_0001, 0, 2, 2);
      add_vec(1, 0, 32'h0000_0001, 1, 1, 1, 32'h0000_0001, 1, 32'h0000_0001, 0, 2, 2);
      add_vec(1, 1, 32'h0000_0002, 1, 1, 1, 32'h0000_0001, 0, 32'h0000_0002, 1, 3, 2);
      add_vec(1, 0, 32'h0000_0003, 1, 1, 1, 32'h0000_0003, 1, 32'h0000_0002, 0, 3, 3);
      add_vec(1, 1, 32'h0000_0004, 1, 1, 1, 32'h0000_0003, 0, 32'h0000_0004, 1, 4, 3);
      add_vec(1, 1, 32'h0000_0005, 1, 1, 1, 32'h0000_0003, 0, 32'h0000_0005, 1, 4, 4);
      add_vec(0, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_0003, 0, 32'h0000_0005, 1, 4, 4);
      add_vec(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_0003, 0, 32'h0000_0005, 1, 4, 4);
      add_vec(1, 0, 32'h0000_AAAA, 0, 0, 1, 32'h0000_AAAA, 1, 32'h0000_0005, 1, 4, 4);

      drive(0, 0, '0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("idle In_Ready", {31'd0, in_ready}, 32'd1);
      check_outputs("reset idle", 32'h0, 0, 32'h0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].in_valid, vecs[i].sel, vecs[i].x, vecs[i].y0_ready, vecs[i].y1_ready);
         #1;
         check_val($sformatf("vec%0d In_Ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_in_ready});
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_y0, vecs[i].exp_y0_valid,
                       vecs[i].exp_y1, vecs[i].exp_y1_valid, vecs[i].exp_cnt0, vecs[i].exp_cnt1);
      end

      // Both buffers are full here; a reset must discard them even with an offered word.
      @(negedge clk);
      drive(1, 1, 32'h1234_5678, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("mid reset", 32'h0, 0, 32'h0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 0, '0, 0, 0);
      @(posedge clk);
      #1;
      check_outputs("post reset", 32'h0, 0, 32'h0, 0, 0, 0);

      // 17 back-to-back words on Y0 then one drain cycle: 17 drains wrap a 4-bit count to 1.
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         drive(1, 0, DW'(k), 1, 0);
         #1;
         check_val($sformatf("stream%0d In_Ready", k), {31'd0, in_ready}, 32'd1);
      end
      @(negedge clk);
      drive(0, 0, '0, 1, 0);
      @(posedge clk);
      #1;
      check_outputs("wrap", 32'd17, 0, 32'h0, 0, 17, 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/demux_1x2_32b_buf.md
Name: demux_1x2_32b_buf

Overview:
- Registered 1-to-2 demultiplexer; the routing counterpart of the datapath 2x1 32-bit mux.
- Accepts one 32-bit word per cycle on a valid/ready input and steers it by Sel into one of two one-entry output buffers, Y0 or Y1.
- Each output buffer drains independently through its own valid/ready pair.
- Sits between the execute/result stage and two consumers, e.g. register-file write port and store path.

Parameters:
- DATA_W, 32, width of X, Y0, Y1.
- CNT_W, 16, width of per-output transfer counters; used only with DEMUX_CNT_EN.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- X  input  DATA_W  input data word.
- Sel  input  1  route select: 0 routes to Y0, 1 routes to Y1; sampled only with In_Valid.
- In_Valid  input  1  X/Sel valid this cycle.
- In_Ready  output  1  block accepts X this cycle (combinational).
- Y0  output  DATA_W  buffer 0 data (registered).
- Y0_Valid  output  1  buffer 0 full.
- Y0_Ready  input  1  consumer 0 takes Y0 this cycle.
- Y1  output  DATA_W  buffer 1 data (registered).
- Y1_Valid  output  1  buffer 1 full.
- Y1_Ready  input  1  consumer 1 takes Y1 this cycle.
- Cnt0  output  CNT_W  words delivered on Y0 (DEMUX_CNT_EN only).
- Cnt1  output  CNT_W  words delivered on Y1 (DEMUX_CNT_EN only).

Behaviour:
- State per buffer i: data register D_i (DATA_W bits) and full flag F_i. Each buffer is a 2-state FSM, EMPTY <-> FULL. Y_i = D_i; Yi_Valid = F_i.
- Reset is synchronous and active-high. While asserted at a rising edge: F0 = F1 = 0, D0 = D1 = 0, counters = 0. Any buffered words are discarded, including mid-transfer. Outputs read 0 / invalid from the first edge after Reset is sampled high. In_Ready is still computed combinationally during reset, but nothing is accepted.
- In_Ready = !F_Sel || Yi_Ready, where i = Sel. It depends on Sel and the target's ready only, never on the other buffer.
- Accept = In_Valid && In_Ready. On accept: D_Sel <= X and F_Sel <= 1 at the next edge. Input-to-output latency is exactly 1 cycle.
- Drain_i = F_i && Yi_Ready. On drain without a same-cycle accept into i, F_i <= 0.
- Simultaneous drain and accept into the same buffer: F_i stays 1 and D_i is replaced with the new X. This gives full throughput of one word per cycle per buffer.
- The non-selected buffer is unaffected by accept. It may drain in the same cycle as an accept into the other buffer.
- While Yi_Valid=1 and Yi_Ready=0, Y_i holds stable.
- In_Valid=0: Sel and X are ignored, and no state changes except drains.
- Yi_Ready while F_i=0 is ignored.
- No reordering within a channel; across channels, ordering is not guaranteed.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined: Cnt0/Cnt1 ports exist. Cnt_i increments by 1 on each Drain_i and wraps modulo 2^CNT_W (all-ones + 1 -> 0). Reset clears to 0. Counter updates are registered, visible the cycle after the drain.
- Undefined: Cnt0/Cnt1 ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - DATA_W default constant (32);
  - CNT_W default constant (16);
  - select constants SEL_Y0 = 1'b0, SEL_Y1 = 1'b1;
  - buffer state encoding EMPTY/FULL.
- One natural sub-module: hold_reg_32b, the one-entry valid/ready holding register (load, data, full, ready, optional counter). It is instantiated twice; the top adds only the Sel steering and the In_Ready mux.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, then 0 with In_Valid=0 -> Y0=Y1=0, Y0_Valid=Y1_Valid=0, In_Ready=1, Cnt0=Cnt1=0.
- Single route: X=32'h00000030, Sel=0, In_Valid=1 for one cycle, Y0_Ready=1 -> next cycle Y0=32'h00000030, Y0_Valid=1, Y1_Valid=0; following cycle Y0_Valid=0, Cnt0=1.
- Backpressure: Sel=1, X=32'h00100000 accepted, Y1_Ready=0, then new X=32'h00000001, Sel=1 -> In_Ready=0, Y1 holds 32'h00100000. Raise Y1_Ready -> In_Ready=1, Y1 becomes 32'h00000001 next cycle with Y1_Valid staying 1.
- Cross-channel independence: Y1 full with Y1_Ready=0; send Sel=0 X=32'h0000ABCD -> accepted (In_Ready=1), Y0=32'h0000ABCD next cycle, Y1 unchanged.
- Full-rate streaming: Sel alternates 0,1,0,1 with X=1,2,3,4 and both readies=1 -> In_Ready stays 1, Y0 shows 1 then 3, Y1 shows 2 then 4, Cnt0=Cnt1=2.
- Reset mid-operation and wrap: both buffers full, assert Reset one cycle -> both Valid=0 and data=0 next cycle. With DEMUX_CNT_EN and CNT_W=4, 17 drains on Y0 -> Cnt0=1.
